vram_port_arbiter: RTL

// - Owns one 8-bit port of the 32 KB dual-port video RAM (15-bit addr, 1-cycle registered read).
// - Shares that port between the CPU bus (read/write handshake) and a built-in fill engine

---
 rtl/vram_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/vram_port_arbiter.sv
// Shares one 8-bit VRAM port between a CPU request/ack bus (priority) and a region fill engine.
// Define VRAM_ARB_ATTR_FILL_EN for 16-bit char+attribute fills (even addr = low byte, odd = high byte).
module vram_port_arbiter #(
    parameter int AW = 15,
    parameter int DW = 8,
`ifdef VRAM_ARB_ATTR_FILL_EN
    localparam int LANES = 2
`else
    localparam int LANES = 1
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [AW-1:0]         cpu_addr,
    input  logic [DW-1:0]         cpu_din,
    output logic                  cpu_ack,
    output logic [DW-1:0]         cpu_dout,
    input  logic                  fill_start,
    input  logic [AW-1:0]         fill_base,
    input  logic [AW-1:0]         fill_len,
    input  logic [LANES*DW-1:0]   fill_data,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_din,
    input  logic [DW-1:0]         mem_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_ACK  = 2'd2
    } cpu_state_t;

    cpu_state_t            state_reg, state_next;
    logic [DW-1:0]         cpu_dout_reg;
    logic                  cpu_issue;
    logic                  rd_capture;

    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic [AW-1:0]         ptr_reg, ptr_next;
    logic [AW-1:0]         rem_reg, rem_next;
    logic [LANES*DW-1:0]   data_reg, data_next;
    logic                  fill_write;
    logic [DW-1:0]         fill_byte;

    // CPU FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // CPU FSM: next state (cpu_req is only looked at in IDLE)
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_next = cpu_we ? ST_ACK : ST_RD1;
                end
            end
            ST_RD1:  state_next = ST_ACK;
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // CPU FSM: outputs; gating with reset keeps the port quiet while reset is held
    always_comb begin
        cpu_issue  = (state_reg == ST_IDLE) && cpu_req && !reset;
        rd_capture = (state_reg == ST_RD1);
        cpu_ack    = (state_reg == ST_ACK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_dout_reg <= '0;
        end else if (rd_capture) begin
            cpu_dout_reg <= mem_dout;
        end
    end

    assign cpu_dout = cpu_dout_reg;

    // The fill engine gets every slot the CPU leaves unused, including RD1 and ACK.
    assign fill_write = busy_reg && !cpu_issue;

`ifdef VRAM_ARB_ATTR_FILL_EN
    assign fill_byte = ptr_reg[0] ? data_reg[2*DW-1:DW] : data_reg[DW-1:0];
`else
    assign fill_byte = data_reg;
`endif

    always_comb begin
        busy_next = busy_reg;
        ptr_next  = ptr_reg;
        rem_next  = rem_reg;
        data_next = data_reg;
        done_next = 1'b0;
        if (!busy_reg) begin
            if (fill_start) begin
                ptr_next  = fill_base;
                rem_next  = fill_len;
                data_next = fill_data;
                busy_next = (fill_len != '0);
                done_next = (fill_len == '0);
            end
        end else if (fill_write) begin
            ptr_next = ptr_reg + AW'(1);
            rem_next = rem_reg - AW'(1);
            if (rem_reg == AW'(1)) begin
                busy_next = 1'b0;
                done_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            ptr_reg  <= '0;
            rem_reg  <= '0;
            data_reg <= '0;
        end else begin
            busy_reg <= busy_next;
            done_reg <= done_next;
            ptr_reg  <= ptr_next;
            rem_reg  <= rem_next;
            data_reg <= data_next;
        end
    end

    assign fill_busy = busy_reg;
    assign fill_done = done_reg;

    // Port mux: CPU issue wins; idle cycles drive zeros on every port signal
    always_comb begin
        mem_en   = cpu_issue || fill_write;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (cpu_issue) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_din  = cpu_we ? cpu_din : '0;
        end else if (fill_write) begin
            mem_we   = 1'b1;
            mem_addr = ptr_reg;
            mem_din  = fill_byte;
        end
    end

endmodule
